// File: rtl/pam_pkg.sv
// Shared constants and types for the PAM time-division receive path.
//   PAM_WIDTH / PAM_DEPTH : default sample width and channels per frame
//   pam_rx_state_t        : receiver alignment state (HUNT / TRACK)
//   slot_bits()           : width of a slot index for a given frame depth
package pam_pkg;

  localparam int PAM_WIDTH = 8;
  localparam int PAM_DEPTH = 8;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } pam_rx_state_t;

  function automatic int slot_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mux_deco_sub.sv
// Slot-address to one-hot write-enable decoder for the staging bank.
//   addr   : slot index to be written
//   en     : a write happens this cycle
//   onehot : one bit per staging entry, at most one set
module mux_deco_sub
  import pam_pkg::*;
#(
  parameter int Depth = PAM_DEPTH
) (
  input  logic [slot_bits(Depth)-1:0] addr,
  input  logic                        en,
  output logic [Depth-1:0]            onehot
);

  localparam int AW = slot_bits(Depth);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < Depth; i++) begin
      onehot[i] = en && (addr == AW'(i));
    end
  end

endmodule

// File: rtl/demux_pam_rx.sv
// Receive end of the PAM time-division channel bus. One sample per slot arrives on a
// shared bus; a frame-sync marker identifies slot 0. Samples are staged until a whole
// frame is in, then all channels are published at once with a one-cycle done pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_sample   : sample on the shared bus
//   in_valid    : in_sample valid this cycle (no backpressure)
//   in_sync     : marks the slot-0 sample, qualified by in_valid
//   outputs     : last complete frame, indexed by channel
//   frame_done  : one-cycle pulse, outputs updated this cycle
//   sync_err    : one-cycle pulse, framing violation seen
//   locked      : receiver aligned to the frame
//   slot        : slot index expected for the next valid sample
//
// state | meaning
// HUNT  | not aligned; waiting for a valid sample carrying sync
// TRACK | aligned; slot counts valid samples since the last sync
module demux_pam_rx
  import pam_pkg::*;
#(
  parameter int Width = PAM_WIDTH,
  parameter int Depth = PAM_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [Width-1:0]            in_sample,
  input  logic                        in_valid,
  input  logic                        in_sync,
  output logic [Width-1:0]            outputs [Depth],
  output logic                        frame_done,
  output logic                        sync_err,
  output logic                        locked,
  output logic [slot_bits(Depth)-1:0] slot
);

  localparam int SW = slot_bits(Depth);
  localparam logic [SW-1:0] LAST_SLOT = SW'(Depth - 1);

  pam_rx_state_t    state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [SW-1:0]    wr_addr;
  logic             wr_en;
  logic             commit_d, commit_q;
  logic             err_d, err_q;
  logic [Depth-1:0] wr_onehot;
  logic [Width-1:0] stage_q [Depth];
  logic [Width-1:0] out_q [Depth];
  logic             frame_done_q, sync_err_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state logic; slot wraps at Depth-1 so non power-of-two depths work
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sync) begin
            state_d = TRACK;
            slot_d  = SW'(1);
          end
        end
        TRACK: begin
          if (in_sync) begin
            slot_d = SW'(1);
          end else if (slot_q == '0) begin
            state_d = HUNT;
            slot_d  = '0;
          end else if (slot_q == LAST_SLOT) begin
            slot_d = '0;
          end else begin
            slot_d = slot_q + SW'(1);
          end
        end
      endcase
    end
  end

  // Output / action decode. A sync sample always lands in entry 0, even when it
  // arrives early, which is how a partial frame gets discarded.
  always_comb begin
    locked   = (state_q == TRACK);
    wr_en    = 1'b0;
    wr_addr  = slot_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    if (in_valid) begin
      if (in_sync) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        err_d   = (state_q == TRACK) && (slot_q != '0);
      end else if (state_q == TRACK) begin
        if (slot_q == '0) begin
          err_d = 1'b1;
        end else begin
          wr_en    = 1'b1;
          commit_d = (slot_q == LAST_SLOT);
        end
      end
    end
  end

  mux_deco_sub #(.Depth(Depth)) u_deco (
    .addr   (wr_addr),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  // Staging bank and publish. commit_q and err_q delay both pulses equally so that
  // a missing-sync error right after a completed frame cannot overlap frame_done.
  // The publish copy reads the bank before a back-to-back slot-0 write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
        out_q[i]   <= '0;
      end
      commit_q     <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (wr_onehot[i]) stage_q[i] <= in_sample;
      end
      if (commit_q) begin
        for (int i = 0; i < Depth; i++) out_q[i] <= stage_q[i];
      end
      commit_q     <= commit_d;
      err_q        <= err_d;
      frame_done_q <= commit_q;
      sync_err_q   <= err_q;
    end
  end

  assign outputs    = out_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign slot       = slot_q;

endmodule
